// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops words from an upstream fifo and sends each as an
// asynchronous serial frame (start, n data bits LSB first, optional
// parity, s stop bits), each bit lasting div clk cycles.
// Ports:
//   clk     block clock, all state on posedge
//   rst_n   asynchronous active-low reset
//   data    fifo data_o word (n bits)
//   status  fifo fill status; any non-zero value means a word is present
//   clk_o   registered one-cycle pop strobe to the fifo
//   tx      registered serial line, idle high
//   busy    registered, high from pop until the last stop bit ends
module uart_tx_drain #(
   parameter int n   = 8,
   parameter int div = 104,
   parameter int p   = 0,
   parameter int s   = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [n-1:0] data,
   input  logic [2:0]   status,
   output logic         clk_o,
   output logic         tx,
   output logic         busy
);

   localparam int BW = (div > 2) ? $clog2(div) : 1;
   localparam int CW = (n > 2) ? $clog2(n) : 1;
   localparam logic [BW-1:0] RELOAD = BW'(div - 1);
   localparam logic [CW-1:0] LAST_D = CW'(n - 1);
   localparam logic [CW-1:0] LAST_S = CW'(s - 1);
   localparam logic          ODD    = (p == 1);
   localparam logic          HASPAR = (p != 0);

   typedef enum logic [2:0] {
      IDLE, POP, LOAD, START, DATA, PARITY, STOP
   } state_e;

   state_e         state_q, state_d;
   logic [1:0]     sync_q,  sync_d;
   logic [BW-1:0]  baud_q,  baud_d;
   logic [CW-1:0]  bit_q,   bit_d;
   logic [n-1:0]   shift_q, shift_d;
   logic           par_q,   par_d;
   logic           tx_q,    tx_d;
   logic           clko_q,  clko_d;
   logic           busy_q,  busy_d;

   logic ne_s;
   logic bdone;

   assign ne_s  = sync_q[1];
   assign bdone = (baud_q == '0);

   assign clk_o = clko_q;
   assign tx    = tx_q;
   assign busy  = busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sync_q  <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         clko_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         clko_q  <= clko_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sync_d  = {sync_q[0], (status != 3'd0)};
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      clko_d  = clko_q;
      busy_d  = busy_q;

      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (ne_s) begin
               clko_d  = 1'b1;
               busy_d  = 1'b1;
               state_d = POP;
            end
         end
         POP: begin
            // fifo exposes the new word on the clk_o rise; sample it next cycle
            clko_d  = 1'b0;
            state_d = LOAD;
         end
         LOAD: begin
            shift_d = data;
            par_d   = (^data) ^ ODD;
            tx_d    = 1'b0;
            baud_d  = RELOAD;
            state_d = START;
         end
         START: begin
            if (bdone) begin
               baud_d  = RELOAD;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         DATA: begin
            if (bdone) begin
               baud_d = RELOAD;
               if (bit_q == LAST_D) begin
                  bit_d = '0;
                  if (HASPAR) begin
                     tx_d    = par_q;
                     state_d = PARITY;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = STOP;
                  end
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         PARITY: begin
            if (bdone) begin
               baud_d  = RELOAD;
               tx_d    = 1'b1;
               bit_d   = '0;
               state_d = STOP;
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         STOP: begin
            if (bdone) begin
               if (bit_q == LAST_S) begin
                  bit_d = '0;
                  // chain straight into the next pop when more words wait
                  if (ne_s) begin
                     clko_d  = 1'b1;
                     state_d = POP;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = IDLE;
                  end
               end else begin
                  bit_d  = bit_q + 1'b1;
                  baud_d = RELOAD;
               end
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: main instance (p=0) fed by a small
// fifo model, plus even- and odd-parity instances with a fixed word.
module tb_uart_tx_drain;

   localparam int DV = 4;

   logic       clk = 1'b0;
   logic       rst_n;

   logic [7:0] mem [16];
   int         wp = 0;
   int         rp = 0;
   logic [7:0] m_data = 8'h00;
   logic [2:0] m_status;
   logic       m_clko, m_tx, m_busy;

   logic [2:0] st_e, st_o;
   logic       e_clko, e_tx, e_busy;
   logic       o_clko, o_tx, o_busy;
   logic [7:0] pdata = 8'h07;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   assign m_status = 3'(wp - rp);

   always @(posedge m_clko) begin
      if (wp != rp) begin
         m_data <= mem[rp[3:0]];
         rp     <= rp + 1;
      end
   end

   uart_tx_drain #(.n(8), .div(DV), .p(0), .s(1)) dut (
      .clk(clk), .rst_n(rst_n), .data(m_data), .status(m_status),
      .clk_o(m_clko), .tx(m_tx), .busy(m_busy)
   );

   uart_tx_drain #(.n(8), .div(DV), .p(2), .s(1)) dut_e (
      .clk(clk), .rst_n(rst_n), .data(pdata), .status(st_e),
      .clk_o(e_clko), .tx(e_tx), .busy(e_busy)
   );

   uart_tx_drain #(.n(8), .div(DV), .p(1), .s(1)) dut_o (
      .clk(clk), .rst_n(rst_n), .data(pdata), .status(st_o),
      .clk_o(o_clko), .tx(o_tx), .busy(o_busy)
   );

   function automatic logic f_tx(input int w);
      case (w)
         0: return m_tx;
         1: return e_tx;
         default: return o_tx;
      endcase
   endfunction

   function automatic logic f_clko(input int w);
      case (w)
         0: return m_clko;
         1: return e_clko;
         default: return o_clko;
      endcase
   endfunction

   function automatic logic f_busy(input int w);
      case (w)
         0: return m_busy;
         1: return e_busy;
         default: return o_busy;
      endcase
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic wait_pop(input int w, input int budget);
      int k = 0;
      while (f_clko(w) !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk($sformatf("pop_wait%0d", w), f_clko(w), 1'b1);
   endtask

   // entered at the negedge where clk_o is high; fr bit 0 is the start bit
   task automatic check_frame(input int w, input logic [15:0] fr,
                              input int nb, input logic nxt);
      chk("pop_tx", f_tx(w), 1'b1);
      chk("pop_busy", f_busy(w), 1'b1);
      @(negedge clk);
      chk("pulse_len", f_clko(w), 1'b0);
      chk("load_tx", f_tx(w), 1'b1);
      for (int k = 0; k < nb; k++) begin
         for (int j = 0; j < DV; j++) begin
            @(negedge clk);
            chk($sformatf("bit%0d_%0d", k, j), f_tx(w), fr[k]);
            chk("frame_busy", f_busy(w), 1'b1);
            chk("frame_clko", f_clko(w), 1'b0);
         end
      end
      @(negedge clk);
      chk("end_clko", f_clko(w), nxt);
      chk("end_busy", f_busy(w), nxt);
      chk("end_tx", f_tx(w), 1'b1);
   endtask

   initial begin
      logic bad;
      rst_n = 1'b0;
      st_e  = 3'd0;
      st_o  = 3'd0;
      mem[0] = 8'h35;
      mem[1] = 8'h01;
      mem[2] = 8'h80;
      wp = 3;

      repeat (3) begin
         @(negedge clk);
         chk("rst_tx", m_tx, 1'b1);
         chk("rst_clko", m_clko, 1'b0);
         chk("rst_busy", m_busy, 1'b0);
      end

      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_lat1", m_clko, 1'b0);
      @(negedge clk);
      chk("rel_lat2", m_clko, 1'b0);
      @(negedge clk);
      chk("rel_lat3", m_clko, 1'b1);

      // word 0x35 in flight; move to the first clk of data bit 3
      repeat (2 + 4 * DV) @(negedge clk);
      chk("bit3_pre", m_tx, 1'b0);
      chk("bit3_busy", m_busy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_tx", m_tx, 1'b1);
      chk("arst_busy", m_busy, 1'b0);
      chk("arst_clko", m_clko, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      wait_pop(0, 10);
      check_frame(0, 16'h0202, 10, 1'b1);
      check_frame(0, 16'h0300, 10, 1'b0);

      bad = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (m_clko !== 1'b0) bad = 1'b1;
      end
      chk("no_third", bad, 1'b0);

      mem[3] = 8'hA5;
      wp = 4;
      wait_pop(0, 10);
      check_frame(0, 16'h034A, 10, 1'b0);

      st_e = 3'd1;
      wait_pop(1, 10);
      st_e = 3'd0;
      check_frame(1, 16'h060E, 11, 1'b0);

      st_o = 3'd4;
      wait_pop(2, 10);
      st_o = 3'd0;
      check_frame(2, 16'h040E, 11, 1'b0);

      bad = 1'b0;
      repeat (1000) begin
         @(negedge clk);
         if (m_clko !== 1'b0 || m_tx !== 1'b1 || m_busy !== 1'b0)
            bad = 1'b1;
      end
      chk("empty_idle", bad, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
